// File: rtl/fp_div_pkg.sv
// Shared definitions for the iterative floating-point divider.
// Contents: FSM state encoding, bit positions in the flag vector, and
// helpers that derive the exponent bias, the word width and the canonical
// quiet NaN from the exponent/fraction widths.
package fp_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int FLAG_W        = 5;
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIV_ZERO  = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, 1 followed by zeros}, built
  // in a 64-bit container; callers keep the low word_w() bits.
  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < exp_w; i++) w[man_w + i] = 1'b1;
    w[man_w - 1] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/fp_div_classify.sv
// Combinational operand classifier for fp_divider_iter.
// Ports:
//   i_a, i_b   : dividend / divisor words {sign, exponent, fraction}
//   o_special  : operands need no mantissa division
//   o_result   : result word for the special case
//   o_flags    : {invalid, div_by_zero, overflow, underflow, inexact}
// Denormal operands are treated as zero.
module fp_div_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] i_a,
  input  logic [EXP_W+MAN_W:0] i_b,
  output logic                 o_special,
  output logic [EXP_W+MAN_W:0] o_result,
  output logic [FLAG_W-1:0]    o_flags
);

  localparam int W = word_w(EXP_W, MAN_W);
  localparam logic [63:0] QNAN_64 = qnan_word(EXP_W, MAN_W);

  logic             w_sign;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_nan, w_a_inf, w_a_zero;
  logic             w_b_nan, w_b_inf, w_b_zero;

  assign w_sign = i_a[W-1] ^ i_b[W-1];
  assign w_ea   = i_a[W-2:MAN_W];
  assign w_eb   = i_b[W-2:MAN_W];
  assign w_fa   = i_a[MAN_W-1:0];
  assign w_fb   = i_b[MAN_W-1:0];

  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_a_zero = ~(|w_ea);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_b_zero = ~(|w_eb);

  always_comb begin
    o_special = 1'b0;
    o_result  = '0;
    o_flags   = '0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      o_special            = 1'b1;
      o_result             = QNAN_64[W-1:0];
      o_flags[FLG_INVALID] = 1'b1;
    end else if (w_a_inf) begin
      o_special = 1'b1;
      o_result  = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_zero) begin
      o_special             = 1'b1;
      o_result              = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags[FLG_DIV_ZERO] = 1'b1;
    end else if (w_a_zero || w_b_inf) begin
      o_special = 1'b1;
      o_result  = {w_sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_divider_iter.sv
// Iterative floating-point divider: restoring mantissa division producing
// one quotient bit per clock, then a single round-to-nearest-even cycle.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready high only when idle)
//   A, B                  : dividend, divisor
//   out_valid / out_ready : result handshake (result held until accepted)
//   result                : quotient A/B
//   exception, flags      : OR of flags; {invalid, dbz, ovf, unf, inexact}
module fp_divider_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 exception,
  output logic [FLAG_W-1:0]    flags
);

  localparam int W     = word_w(EXP_W, MAN_W);
  localparam int QW    = MAN_W + 3;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(QW + 1);
  localparam logic signed [EW-1:0] BIAS_S    = EW'(exp_bias(EXP_W));
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO_S    = '0;
  localparam logic [CNT_W-1:0]     LAST_STEP = CNT_W'(QW - 1);

  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [W-1:0]         r_result;
  logic [FLAG_W-1:0]    r_flags;
  logic                 r_sign;
  logic signed [EW-1:0] r_exp;
  logic [MAN_W:0]       r_manb;
  logic [MAN_W+1:0]     r_rem;
  logic [QW-1:0]        r_quo;

  logic                 w_special;
  logic [W-1:0]         w_spec_result;
  logic [FLAG_W-1:0]    w_spec_flags;
  logic signed [EW-1:0] w_exp_init;
  logic [MAN_W+2:0]     w_diff;
  logic                 w_borrow;
  logic [MAN_W+1:0]     w_rem_sel;

  logic                 w_norm, w_guard, w_sticky, w_rup, w_carry;
  logic [MAN_W:0]       w_mant;
  logic [MAN_W+1:0]     w_mant_r;
  logic [MAN_W-1:0]     w_frac_r;
  logic signed [EW-1:0] w_exp_r;
  logic [W-1:0]         w_rnd_result;
  logic [FLAG_W-1:0]    w_rnd_flags;

  fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify (
    .i_a       (A),
    .i_b       (B),
    .o_special (w_special),
    .o_result  (w_spec_result),
    .o_flags   (w_spec_flags)
  );

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign result     = r_result;
  assign flags      = r_flags;
  assign exception  = |r_flags;

  assign w_exp_init = $signed({2'b00, A[W-2:MAN_W]}) - $signed({2'b00, B[W-2:MAN_W]}) + BIAS_S;

  // Restoring step: subtract the divisor if it fits, then shift the
  // partial remainder left for the next quotient bit.
  assign w_diff    = {1'b0, r_rem} - {2'b00, r_manb};
  assign w_borrow  = w_diff[MAN_W+2];
  assign w_rem_sel = w_borrow ? r_rem : w_diff[MAN_W+1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_state_nxt = w_special ? ST_DONE : ST_DIVIDE;
      ST_DIVIDE: if (r_cnt == LAST_STEP) w_state_nxt = ST_ROUND;
      ST_ROUND:  w_state_nxt = ST_DONE;
      ST_DONE:   if (out_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Quotient lies in (0.5, 2): a clear MSB means one normalising shift.
  always_comb begin
    w_norm   = r_quo[QW-1];
    w_mant   = w_norm ? r_quo[QW-1:2] : r_quo[QW-2:1];
    w_guard  = w_norm ? r_quo[1] : r_quo[0];
    w_sticky = (w_norm & r_quo[0]) | (|r_rem);
    w_rup    = rne_up(w_mant[0], w_guard, w_sticky);
    w_mant_r = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_rup};
    w_carry  = w_mant_r[MAN_W+1];
    // A rounding carry leaves 10..0, so the fraction is the zero bits below the MSB.
    w_frac_r = w_carry ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
    w_exp_r  = r_exp - $signed({{(EW-1){1'b0}}, ~w_norm})
                     + $signed({{(EW-1){1'b0}}, w_carry});
    w_rnd_flags              = '0;
    w_rnd_flags[FLG_INEXACT] = w_guard | w_sticky;
    w_rnd_result             = {r_sign, w_exp_r[EXP_W-1:0], w_frac_r};
    if (w_exp_r >= EXP_MAX_S) begin
      w_rnd_result               = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rnd_flags[FLG_OVERFLOW]  = 1'b1;
      w_rnd_flags[FLG_INEXACT]   = 1'b1;
    end else if (w_exp_r <= ZERO_S) begin
      w_rnd_result               = {r_sign, {(EXP_W+MAN_W){1'b0}}};
      w_rnd_flags[FLG_UNDERFLOW] = 1'b1;
      w_rnd_flags[FLG_INEXACT]   = 1'b1;
    end
  end

  // Control and visible outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_cnt <= '0;
            if (w_special) begin
              r_result <= w_spec_result;
              r_flags  <= w_spec_flags;
            end
          end
        end
        ST_DIVIDE: r_cnt <= r_cnt + 1'b1;
        ST_ROUND: begin
          r_result <= w_rnd_result;
          r_flags  <= w_rnd_flags;
        end
        default: ;
      endcase
    end
  end

  // Mantissa datapath
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && in_valid) begin
      r_sign <= A[W-1] ^ B[W-1];
      r_exp  <= w_exp_init;
      r_manb <= {1'b1, B[MAN_W-1:0]};
      r_rem  <= {1'b0, 1'b1, A[MAN_W-1:0]};
      r_quo  <= '0;
    end else if (r_state == ST_DIVIDE) begin
      r_quo <= {r_quo[QW-2:0], ~w_borrow};
      r_rem <= w_rem_sel << 1;
    end
  end

endmodule

// File: tb/tb_fp_divider_iter.sv
module tb_fp_divider_iter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, exception;
  logic [31:0] A, B, result;
  logic [4:0]  flags;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_exception;
  logic [15:0] h_A, h_B, h_result;
  logic [4:0]  h_flags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_divider_iter dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exception(exception), .flags(flags)
  );

  fp_divider_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset_n(reset_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .A(h_A), .B(h_B), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .exception(h_exception), .flags(h_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_accept(input bit half, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!(half ? h_in_ready : in_ready) && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("accept_rdy", 32'(half ? h_in_ready : in_ready), 32'd1);
    if (half) begin h_A = a[15:0]; h_B = b[15:0]; h_in_valid = 1'b1; end
    else      begin A = a; B = b; in_valid = 1'b1; end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    h_in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit half, output int lat);
    lat = 1;
    while (!(half ? h_out_valid : out_valid) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out(input bit half, input string tag);
    if (half) h_out_ready = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready   = 1'b0;
    h_out_ready = 1'b0;
    check({tag, "_in_ready"},  32'(half ? h_in_ready : in_ready),   32'd1);
    check({tag, "_out_valid"}, 32'(half ? h_out_valid : out_valid), 32'd0);
  endtask

  task automatic run_op(input bit half, input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res,
                        input logic [4:0] flg, input int lat_exp);
    int lat;
    do_accept(half, a, b);
    wait_done(half, lat);
    check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    check({tag, "_result"},  half ? {16'h0, h_result} : result, res);
    check({tag, "_flags"},   32'(half ? h_flags : flags), 32'(flg));
    check({tag, "_exc"},     32'(half ? h_exception : exception), 32'(|flg));
    release_out(half, tag);
  endtask

  initial begin
    int lat;
    reset_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_A = '0; h_B = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_flags",     32'(flags),     32'd0);
    check("rst_exc",       32'(exception), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_op(0, "div6_2",  32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);
    run_op(0, "div1_3",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);
    run_op(0, "neg6_2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 28);
    run_op(0, "dbz",     32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
    run_op(0, "zz",      32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
    run_op(0, "nan_in",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
    run_op(0, "ninf",    32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 1);
    run_op(0, "ovf",     32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 28);
    run_op(0, "unf",     32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28);
    run_op(0, "denorm",  32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1);

    // Back-pressure: result must stay put while operands churn.
    do_accept(0, 32'h40C00000, 32'h40000000);
    wait_done(0, lat);
    check("hold_latency", 32'(lat), 32'd28);
    for (int i = 0; i < 10; i++) begin
      A = $urandom; B = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_result",    result,          32'h40400000);
      check("hold_flags",     32'(flags),      32'd0);
      check("hold_in_ready",  32'(in_ready),   32'd0);
      check("hold_out_valid", 32'(out_valid),  32'd1);
    end
    in_valid = 1'b0;
    release_out(0, "hold_rel");
    run_op(0, "after_hold", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);

    // Reset in the middle of DIVIDE iteration 10.
    do_accept(0, 32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_result",    result,         32'd0);
    check("midrst_flags",     32'(flags),     32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_op(0, "post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);

    run_op(1, "h_div6_2", 32'h4600, 32'h4000, 32'h4200, 5'b00000, 15);
    run_op(1, "h_dbz",    32'h3C00, 32'h0000, 32'h7C00, 5'b01000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
